// File: rtl/nios_dbg_pkg.sv
// rtl/nios_dbg_pkg.sv - shared types and constants for the debug scan master
package nios_dbg_pkg;

  localparam int DR_WIDTH_DEF = 38;
  localparam int IR_WIDTH_DEF = 2;

  // Instruction codes understood by the CPU debug slave
  localparam logic [1:0] IR_OCIMEM   = 2'd0;
  localparam logic [1:0] IR_TRACE    = 2'd1;
  localparam logic [1:0] IR_BREAK    = 2'd2;
  localparam logic [1:0] IR_TRACEMEM = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    UIR,
    CDR,
    SDR,
    UDR,
    RTI,
    RSP
  } scan_state_e;

endpackage

// File: rtl/nios_dbg_tck_gen.sv
// rtl/nios_dbg_tck_gen.sv - tck divider with rise and low-phase-start pulses
module nios_dbg_tck_gen #(
  parameter int TCK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en_i,
  output logic tck_o,
  output logic tck_rise_o,
  output logic tck_fall_start_o
);

  localparam int CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TCK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic          tck_q;
  logic          last;

  // Pulses describe what the coming clk edge will do to tck, so the FSM
  // can act on that same edge.
  assign last             = (cnt_q == CNT_LAST);
  assign tck_rise_o       = en_i && last && !tck_q;
  assign tck_fall_start_o = en_i && last && tck_q;
  assign tck_o            = tck_q;

  // Half-period counter; idles with tck low whenever disabled
  always_ff @(posedge clk) begin
    if (!reset_n || !en_i) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else if (last) begin
      cnt_q <= '0;
      tck_q <= ~tck_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/nios_dbg_scan_master.sv
// rtl/nios_dbg_scan_master.sv - virtual-JTAG scan initiator for the CPU debug slave
module nios_dbg_scan_master
  import nios_dbg_pkg::*;
#(
  parameter int DR_WIDTH = DR_WIDTH_DEF,
  parameter int IR_WIDTH = IR_WIDTH_DEF,
  parameter int TCK_DIV  = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic [IR_WIDTH-1:0] rsp_ir_out,
  output logic                tck,
  output logic                tdi,
  input  logic                tdo,
  output logic [IR_WIDTH-1:0] ir_in,
  input  logic [IR_WIDTH-1:0] ir_out,
  output logic                vs_uir,
  output logic                vs_cdr,
  output logic                vs_sdr,
  output logic                vs_udr,
  output logic                jtag_state_rti
);

  localparam int BW = $clog2(DR_WIDTH + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DR_WIDTH - 1);

  scan_state_e         state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DR_WIDTH-1:0] rsp_dr_q, rsp_dr_d;
  logic [IR_WIDTH-1:0] rsp_ir_out_q, rsp_ir_out_d;
  logic                tdi_q, tdi_d;
  logic [IR_WIDTH-1:0] ir_in_q, ir_in_d;
  logic [DR_WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]       bit_cnt_q, bit_cnt_d;

  logic tck_en;
  logic tck_rise;
  logic tck_fall_start;

  // tck only runs while a scan sequence is on the wire
  assign tck_en = (state_q != IDLE) && (state_q != RSP);

  nios_dbg_tck_gen #(
    .TCK_DIV (TCK_DIV)
  ) u_tck_gen (
    .clk              (clk),
    .reset_n          (reset_n),
    .en_i             (tck_en),
    .tck_o            (tck),
    .tck_rise_o       (tck_rise),
    .tck_fall_start_o (tck_fall_start)
  );

  // State changes coincide with low-phase starts, so decoded strobes obey
  // the phase rule and are exclusive by construction.
  assign vs_uir         = (state_q == UIR);
  assign vs_cdr         = (state_q == CDR);
  assign vs_sdr         = (state_q == SDR);
  assign vs_udr         = (state_q == UDR);
  assign jtag_state_rti = (state_q == RTI);

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_dr     = rsp_dr_q;
  assign rsp_ir_out = rsp_ir_out_q;
  assign tdi        = tdi_q;
  assign ir_in      = ir_in_q;

  // Next-state and datapath: acceptance, scan sequencing, response handshake
  always_comb begin
    state_d      = state_q;
    cmd_ready_d  = cmd_ready_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_dr_d     = rsp_dr_q;
    rsp_ir_out_d = rsp_ir_out_q;
    tdi_d        = tdi_q;
    ir_in_d      = ir_in_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;

    case (state_q)
      IDLE: begin
        if (cmd_ready_q) begin
          if (cmd_valid) begin
            ir_in_d     = cmd_ir;
            shift_d     = cmd_dr;
            cmd_ready_d = 1'b0;
          end
        end else begin
          // One cycle after acceptance the sequence starts with tck low
          state_d   = UIR;
          bit_cnt_d = '0;
        end
      end
      UIR: begin
        if (tck_rise) begin
          rsp_ir_out_d = ir_out;
        end
        if (tck_fall_start) begin
          state_d = CDR;
        end
      end
      CDR: begin
        if (tck_fall_start) begin
          state_d = SDR;
          tdi_d   = shift_q[0];
        end
      end
      SDR: begin
        if (tck_rise) begin
          shift_d = {tdo, shift_q[DR_WIDTH-1:1]};
        end
        if (tck_fall_start) begin
          if (bit_cnt_q == BIT_LAST) begin
            state_d = UDR;
            tdi_d   = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            // Present the bit that the last rising tck shifted into place
            tdi_d     = shift_q[0];
          end
        end
      end
      UDR: begin
        if (tck_fall_start) begin
          state_d = RTI;
        end
      end
      RTI: begin
        if (tck_fall_start) begin
          state_d     = RSP;
          rsp_valid_d = 1'b1;
          rsp_dr_d    = shift_q;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous abort on reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cmd_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_dr_q     <= '0;
      rsp_ir_out_q <= '0;
      tdi_q        <= 1'b0;
      ir_in_q      <= '0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_dr_q     <= rsp_dr_d;
      rsp_ir_out_q <= rsp_ir_out_d;
      tdi_q        <= tdi_d;
      ir_in_q      <= ir_in_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
    end
  end

endmodule

// File: tb/tb_nios_dbg_scan_master.sv
// tb/tb_nios_dbg_scan_master.sv - scoreboard bench for the debug scan master
module tb_nios_dbg_scan_master;
  import nios_dbg_pkg::*;

  localparam int DRW = DR_WIDTH_DEF;
  localparam int IRW = IR_WIDTH_DEF;
  localparam int TD  = 2;
  localparam int LAT = (DRW + 4) * 2 * TD + 1;
  localparam logic [DRW-1:0] ONES = '1;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [IRW-1:0] cmd_ir = '0;
  logic [DRW-1:0] cmd_dr = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b1;
  logic [DRW-1:0] rsp_dr;
  logic [IRW-1:0] rsp_ir_out;
  logic           tck, tdi, tdo;
  logic [IRW-1:0] ir_in;
  logic [IRW-1:0] ir_out = '0;
  logic           vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti;

  int tdo_mode = 0;
  assign tdo = (tdo_mode == 0) ? tdi : (tdo_mode == 1) ? 1'b1 : ~tdi;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [DRW+IRW-1:0] exp_q[$];
  logic [IRW-1:0]     exp_ir = '0;
  logic               mon_en = 1'b0;
  int                 rise_cnt[6];
  int                 order_q[$];
  logic               prev_tck = 1'b0;
  logic               prev_tdi = 1'b0;
  int                 prev_code = 0;
  int                 high_run = 0;
  int                 low_run = 0;

  nios_dbg_scan_master #(
    .DR_WIDTH (DRW),
    .IR_WIDTH (IRW),
    .TCK_DIV  (TD)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_ir         (cmd_ir),
    .cmd_dr         (cmd_dr),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_dr         (rsp_dr),
    .rsp_ir_out     (rsp_ir_out),
    .tck            (tck),
    .tdi            (tdi),
    .tdo            (tdo),
    .ir_in          (ir_in),
    .ir_out         (ir_out),
    .vs_uir         (vs_uir),
    .vs_cdr         (vs_cdr),
    .vs_sdr         (vs_sdr),
    .vs_udr         (vs_udr),
    .jtag_state_rti (jtag_state_rti)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Protocol monitor and response scoreboard, sampled mid-low clk phase
  always @(negedge clk) begin
    int code;
    logic [DRW+IRW-1:0] e;
    #1;
    code = vs_uir ? 1 : vs_cdr ? 2 : vs_sdr ? 3 : vs_udr ? 4 : jtag_state_rti ? 5 : 0;
    if (mon_en && reset_n) begin
      vectors++;
      if ($countones({vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti}) > 1) begin
        miscompares++;
        $display("FAIL strobe_excl: got %b, want at most one set", {vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti});
      end
      vectors++;
      if (tdi !== prev_tdi && !(prev_tck === 1'b1 && tck === 1'b0)) begin
        miscompares++;
        $display("FAIL tdi_phase: tdi changed to %b outside low-phase start (tck %b->%b)", tdi, prev_tck, tck);
      end
      if (code == 0) begin
        vectors++;
        if (tck !== 1'b0) begin
          miscompares++;
          $display("FAIL tck_idle: got %b, want 0", tck);
        end
      end
      if (code != 0 || rsp_valid) begin
        vectors++;
        if (ir_in !== exp_ir) begin
          miscompares++;
          $display("FAIL ir_in_stable: got %h, want %h", ir_in, exp_ir);
        end
      end
      if (tck && !prev_tck) begin
        rise_cnt[code]++;
        vectors++;
        if (low_run != TD) begin
          miscompares++;
          $display("FAIL tck_low_len: got %0d, want %0d", low_run, TD);
        end
      end
      if (!tck && prev_tck) begin
        vectors++;
        if (high_run != TD) begin
          miscompares++;
          $display("FAIL tck_high_len: got %0d, want %0d", high_run, TD);
        end
      end
      if (code != 0 && code != prev_code) order_q.push_back(code);
    end
    if (tck) high_run = prev_tck ? high_run + 1 : 1;
    else     low_run  = (code != 0) ? ((prev_tck || prev_code == 0) ? 1 : low_run + 1) : 0;
    prev_tck  = tck;
    prev_tdi  = tdi;
    prev_code = code;

    if (reset_n && rsp_valid && rsp_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL rsp_unexpected: got %h/%h, want no response", rsp_dr, rsp_ir_out);
      end else begin
        e = exp_q.pop_front();
        if ({rsp_dr, rsp_ir_out} !== e) begin
          miscompares++;
          $display("FAIL rsp_data: got %h/%h, want %h/%h", rsp_dr, rsp_ir_out, e[DRW+IRW-1:IRW], e[IRW-1:0]);
        end
      end
    end
  end

  task automatic send(input logic [IRW-1:0] ir, input logic [DRW-1:0] dr,
                      input logic [DRW+IRW-1:0] expv, output int acc);
    bit done;
    done = 0;
    acc = -1;
    cmd_ir = ir;
    cmd_dr = dr;
    cmd_valid = 1'b1;
    for (int i = 0; i < 2000 && !done; i++) begin
      if (cmd_ready === 1'b1) begin
        acc = cyc;
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
    exp_q.push_back(expv);
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL cmd_accept_timeout: got cmd_ready %b, want 1", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    exp_ir = ir;
    vectors++;
    if (cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL cmd_ready_busy: got %b, want 0", cmd_ready);
    end
  endtask

  task automatic wait_rsp(output int seen);
    bit done;
    done = 0;
    seen = -1;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        seen = cyc;
        done = 1;
      end
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL rsp_timeout: got rsp_valid %b, want 1", rsp_valid);
    end
  endtask

  task automatic clear_trace();
    order_q.delete();
    for (int i = 0; i < 6; i++) rise_cnt[i] = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rst_cmd_ready: got %b, want 1", cmd_ready); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_rsp_valid: got %b, want 0", rsp_valid); end
    vectors++; if (rsp_dr !== '0) begin miscompares++; $display("FAIL rst_rsp_dr: got %h, want 0", rsp_dr); end
    vectors++; if (rsp_ir_out !== '0) begin miscompares++; $display("FAIL rst_rsp_ir_out: got %h, want 0", rsp_ir_out); end
    vectors++; if (tck !== 1'b0) begin miscompares++; $display("FAIL rst_tck: got %b, want 0", tck); end
    vectors++; if (tdi !== 1'b0) begin miscompares++; $display("FAIL rst_tdi: got %b, want 0", tdi); end
    vectors++; if (ir_in !== '0) begin miscompares++; $display("FAIL rst_ir_in: got %h, want 0", ir_in); end
    vectors++;
    if ({vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti} !== 5'b0) begin
      miscompares++;
      $display("FAIL rst_strobes: got %b, want 00000", {vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti});
    end
    reset_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
  endtask

  task automatic test_loopback();
    int acc, seen, got_order;
    int exp_r[6];
    logic [DRW-1:0] dr;
    exp_r = '{0, 1, 1, DRW, 1, 1};
    dr = 38'h2A_5555_AAAA;
    tdo_mode = 0;
    ir_out = 2'b11;
    rsp_ready = 1'b1;
    clear_trace();
    send(IR_TRACE, dr, {dr, 2'b11}, acc);
    wait_rsp(seen);
    vectors++;
    if (seen - acc - 1 != LAT) begin
      miscompares++;
      $display("FAIL loop_latency: got %0d, want %0d", seen - acc - 1, LAT);
    end
    vectors++;
    if (ir_in !== IR_TRACE) begin
      miscompares++;
      $display("FAIL loop_ir_in: got %h, want %h", ir_in, IR_TRACE);
    end
    @(negedge clk);
    got_order = 0;
    foreach (order_q[i]) got_order = got_order * 10 + order_q[i];
    vectors++;
    if (got_order != 12345) begin
      miscompares++;
      $display("FAIL strobe_order: got %0d, want 12345", got_order);
    end
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (rise_cnt[i] != exp_r[i]) begin
        miscompares++;
        $display("FAIL strobe_len_%0d: got %0d, want %0d", i, rise_cnt[i], exp_r[i]);
      end
    end
  endtask

  task automatic test_capture();
    int acc, seen;
    tdo_mode = 1;
    ir_out = 2'b10;
    send(IR_BREAK, '0, {ONES, 2'b10}, acc);
    wait_rsp(seen);
    vectors++;
    if (rsp_dr !== 38'h3F_FFFF_FFFF) begin
      miscompares++;
      $display("FAIL cap_rsp_dr: got %h, want %h", rsp_dr, 38'h3F_FFFF_FFFF);
    end
    vectors++;
    if (rsp_ir_out !== 2'b10) begin
      miscompares++;
      $display("FAIL cap_rsp_ir_out: got %b, want 10", rsp_ir_out);
    end
    @(negedge clk);
  endtask

  task automatic test_invert();
    int acc, seen;
    logic [63:0] r;
    logic [DRW-1:0] dr;
    logic [IRW-1:0] ir, st;
    tdo_mode = 2;
    for (int k = 0; k < 3; k++) begin
      r = {$urandom(), $urandom()};
      dr = r[DRW-1:0];
      ir = IRW'($urandom_range(0, 3));
      st = IRW'($urandom_range(0, 3));
      ir_out = st;
      send(ir, dr, {~dr, st}, acc);
      wait_rsp(seen);
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    int acc, seen;
    logic [DRW-1:0] dr1, dr2;
    dr1 = 38'h15_0F0F_3C3C;
    dr2 = 38'h0A_F0F0_C3C3;
    tdo_mode = 0;
    ir_out = 2'b00;
    rsp_ready = 1'b0;
    send(IR_OCIMEM, dr1, {dr1, 2'b00}, acc);
    wait_rsp(seen);
    cmd_valid = 1'b1;
    cmd_ir = IR_TRACEMEM;
    cmd_dr = dr2;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_dr !== dr1 || cmd_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold: got valid %b dr %h ready %b, want 1 %h 0", rsp_valid, rsp_dr, cmd_ready, dr1);
      end
    end
    exp_q.push_back({dr2, 2'b00});
    rsp_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release: got valid %b ready %b, want 0 1", rsp_valid, cmd_ready);
    end
    acc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    exp_ir = IR_TRACEMEM;
    vectors++;
    if (cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_accept_next: got cmd_ready %b, want 0", cmd_ready);
    end
    wait_rsp(seen);
    vectors++;
    if (seen - acc - 1 != LAT) begin
      miscompares++;
      $display("FAIL bp_latency: got %0d, want %0d", seen - acc - 1, LAT);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_sdr();
    int acc, rises;
    logic p;
    bit hit, seen_rsp;
    logic [DRW+IRW-1:0] dropped;
    logic [DRW-1:0] dr;
    dr = 38'h12_3456_789A;
    mon_en = 1'b0;
    tdo_mode = 0;
    rsp_ready = 1'b1;
    send(IR_TRACE, dr, {dr, ir_out}, acc);
    rises = 0;
    p = tck;
    hit = 0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge clk);
      if (vs_sdr && tck && !p) rises++;
      p = tck;
      if (rises == 10) hit = 1;
    end
    vectors++;
    if (!hit) begin
      miscompares++;
      $display("FAIL mid_sdr_reach: got %0d rises, want 10", rises);
    end
    reset_n = 1'b0;
    @(negedge clk);
    vectors++; if (tck !== 1'b0) begin miscompares++; $display("FAIL abort_tck: got %b, want 0", tck); end
    vectors++; if (vs_sdr !== 1'b0) begin miscompares++; $display("FAIL abort_vs_sdr: got %b, want 0", vs_sdr); end
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL abort_cmd_ready: got %b, want 1", cmd_ready); end
    reset_n = 1'b1;
    dropped = exp_q.pop_back();
    seen_rsp = 0;
    repeat (200) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) seen_rsp = 1;
    end
    vectors++;
    if (seen_rsp) begin
      miscompares++;
      $display("FAIL abort_no_rsp: got rsp_valid 1, want 0 (dropped %h)", dropped);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_back_to_back();
    int acc1, acc2, seen1, seen2;
    logic [DRW-1:0] da, db;
    da = 38'h00_DEAD_BEEF;
    db = 38'h3C_0000_0001;
    tdo_mode = 0;
    ir_out = 2'b01;
    rsp_ready = 1'b1;
    send(IR_OCIMEM, da, {da, 2'b01}, acc1);
    wait_rsp(seen1);
    send(IR_BREAK, db, {db, 2'b01}, acc2);
    vectors++;
    if (acc2 - seen1 != 1) begin
      miscompares++;
      $display("FAIL b2b_accept_gap: got %0d, want 1", acc2 - seen1);
    end
    wait_rsp(seen2);
    vectors++;
    if (seen2 - acc2 - 1 != LAT) begin
      miscompares++;
      $display("FAIL b2b_latency: got %0d, want %0d", seen2 - acc2 - 1, LAT);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_capture();
    test_invert();
    test_backpressure();
    test_reset_mid_sdr();
    test_back_to_back();
    repeat (4) @(negedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
